// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared types and constants for the APB register slave:
//                FSM state encoding, ID register value and error codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    // Slave transfer state machine encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Read-only identification word held at register index 0
    localparam logic [31:0] c_id_value = 32'hA5B0_0001;

    // Transfer error classification
    localparam logic [1:0] c_err_none     = 2'd0;
    localparam logic [1:0] c_err_range    = 2'd1;
    localparam logic [1:0] c_err_align    = 2'd2;
    localparam logic [1:0] c_err_readonly = 2'd3;

endpackage
`default_nettype wire

// File: rtl/apb_slave_regs_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_slave_regs_if
//  Description : APB bus signal bundle between bridge (master) and the
//                register slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface apb_slave_regs_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface
`default_nettype wire

// File: rtl/apb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : apb_regfile
//  Description : 32-bit register array with one write port and one
//                combinational read port. Index 0 holds the fixed ID word
//                and ignores writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_regfile
    import apb_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  wire logic             hclk,
    input  wire logic             hresetn,
    input  wire logic             wr_en,
    input  wire logic [IDX_W-1:0] wr_idx,
    input  wire logic [31:0]      wr_data,
    input  wire logic [IDX_W-1:0] rd_idx,
    output logic      [31:0]      rd_data
);

    logic [31:0] r_mem [NUM_REGS];

    // Storage: reset loads the ID word at index 0 and clears the rest
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= (i == 0) ? c_id_value : 32'h0;
            end
        end else if (wr_en && (wr_idx != '0)) begin
            r_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/apb_slave_regs.sv
`default_nettype none
// ============================================================================
//  Module      : apb_slave_regs
//  Description : APB slave exposing NUM_REGS 32-bit registers at BASE_ADDR.
//                Three-state FSM (IDLE/SETUP/ACCESS), optional wait-state
//                counter, address/alignment/read-only error decode.
//                Macro APB_SLAVE_WAIT_STATES_EN enables WAIT_CYCLES wait
//                states; without it every transfer completes in its first
//                ACCESS cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int          NUM_REGS    = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input wire logic        hclk,
    input wire logic        hresetn,
    apb_slave_regs_if.slave bus
);

    localparam int IDX_W      = $clog2(NUM_REGS);
    localparam int REGION_LSB = IDX_W + 2;

    apb_state_e       r_state;
    apb_state_e       w_next;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_write;
    logic             w_latch;
    logic             w_cnt_zero;
    logic             w_ready;
    logic [1:0]       w_err_code;
    logic             w_err;
    logic             w_wr_en;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rd_data;

`ifdef APB_SLAVE_WAIT_STATES_EN
    logic [3:0] r_cnt;

    // Wait counter: loaded on entry to ACCESS, counts down to the ready cycle
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_cnt <= 4'd0;
        end else if (w_latch) begin
            r_cnt <= 4'(WAIT_CYCLES);
        end else if ((r_state == ST_ACCESS) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign w_cnt_zero = (r_cnt == 4'd0);
`else
    // Counter removed: WAIT_CYCLES has no effect and ACCESS is always ready
    localparam int c_eff_wait = WAIT_CYCLES * 0;
    assign w_cnt_zero = (c_eff_wait == 0);
`endif

    // Address phase values are captured once, when SETUP advances to ACCESS
    assign w_latch = (r_state == ST_SETUP) && bus.psel;

    // State register
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; penable seen in IDLE is a protocol violation and ignored
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.psel && !bus.penable) w_next = ST_SETUP;
            end
            ST_SETUP: begin
                w_next = bus.psel ? ST_ACCESS : ST_IDLE;
            end
            ST_ACCESS: begin
                if (w_cnt_zero) begin
                    w_next = (bus.psel && !bus.penable) ? ST_SETUP : ST_IDLE;
                end else if (!bus.psel) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Latched transfer attributes; bus changes after SETUP are not observed
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_write <= 1'b0;
        end else if (w_latch) begin
            r_addr  <= bus.paddr;
            r_wdata <= bus.pwdata;
            r_write <= bus.pwrite;
        end
    end

    assign w_idx = r_addr[IDX_W+1:2];

    // Error decode on the latched address: region, alignment, read-only ID
    always_comb begin
        w_err_code = c_err_none;
        if (r_addr[31:REGION_LSB] != BASE_ADDR[31:REGION_LSB]) begin
            w_err_code = c_err_range;
        end else if (r_addr[1:0] != 2'b00) begin
            w_err_code = c_err_align;
        end else if (r_write && (w_idx == '0)) begin
            w_err_code = c_err_readonly;
        end
    end

    assign w_err   = (w_err_code != c_err_none);
    assign w_ready = (r_state == ST_ACCESS) && w_cnt_zero;
    assign w_wr_en = w_ready && r_write && !w_err;

    assign bus.pready  = w_ready;
    assign bus.pslverr = w_ready && w_err;
    assign bus.prdata  = (w_ready && !r_write && !w_err) ? w_rd_data : 32'h0;

    apb_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .wr_en    (w_wr_en),
        .wr_idx   (w_idx),
        .wr_data  (r_wdata),
        .rd_idx   (w_idx),
        .rd_data  (w_rd_data)
    );

endmodule
`default_nettype wire

// File: doc/apb_slave_regs.md
APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, meaning number of 32-bit registers (power of 2, 4..64).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning region base, aligned to NUM_REGS*4.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states per access (0..15).
REQ-004 SHALL have one clock and an asynchronous active-low reset, ports hclk and hresetn.
REQ-005 SHALL have port hclk, input, 1, rising-edge clock.
REQ-006 SHALL have port hresetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port psel, input, 1, slave select from the bridge.
REQ-008 SHALL have port penable, input, 1, access phase.
REQ-009 SHALL have port pwrite, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have port paddr, input, 32, byte address.
REQ-011 SHALL have port pwdata, input, 32, write data.
REQ-012 SHALL have port prdata, output, 32, read data.
REQ-013 SHALL have port pready, output, 1, transfer complete.
REQ-014 SHALL have port pslverr, output, 1, transfer error.

Function
REQ-015 SHALL implement an FSM with states IDLE, SETUP and ACCESS.
REQ-016 SHALL move from IDLE to SETUP on psel=1 and penable=0.
REQ-017 SHALL move from SETUP to ACCESS on the next edge, loading the wait counter with WAIT_CYCLES and latching paddr, pwrite and pwdata.
REQ-018 SHALL decrement the wait counter each ACCESS cycle while it is nonzero.
REQ-019 SHALL decode pready = 1 combinationally from registers only, when state=ACCESS and counter=0; first pready is therefore in setup cycle + 1 + WAIT_CYCLES.
REQ-020 SHALL, after the pready cycle, go to SETUP if psel=1 and penable=0 (back-to-back), else to IDLE.
REQ-021 SHALL, on psel=0 during SETUP or ACCESS, abort to IDLE with no register update and no pready.
REQ-022 SHALL treat penable=1 seen in IDLE as a protocol violation: ignored, state stays IDLE, no pready.
REQ-023 SHALL flag an error when paddr[31:log2(NUM_REGS*4)] differs from BASE_ADDR, when paddr[1:0] is not 0, or on a write to index 0.
REQ-024 SHALL drive pslverr=1 only in the pready cycle of an erroring transfer, and 0 at all other times.
REQ-025 SHALL hold register index 0 as read-only ID constant 32'hA5B0_0001.
REQ-026 SHALL commit a write at the edge closing the pready cycle, only when pwrite=1 and there is no error.
REQ-027 SHALL drive prdata with the register at index paddr[log2(NUM_REGS)+1:2] during a read pready cycle, 0 on an erroring read, and 0 outside pready cycles.
REQ-028 SHALL ignore changes to paddr, pwrite and pwdata after SETUP; the latched values are authoritative.

Reset
REQ-029 SHALL, on hresetn=0, immediately force state=IDLE, counter=0, pready=0, pslverr=0, prdata=0, registers 1..NUM_REGS-1 to 0, and index 0 to its ID.
REQ-030 SHALL drop an in-flight transfer on reset with no write, and accept a new SETUP on the first edge after deassertion.

Configuration
REQ-031 SHALL honour macro APB_SLAVE_WAIT_STATES_EN: when defined, WAIT_CYCLES is used as specified.
REQ-032 SHALL, when APB_SLAVE_WAIT_STATES_EN is undefined, compile out the counter and complete every transfer in the first ACCESS cycle (effective WAIT_CYCLES=0).

Structure
REQ-033 SHALL place the FSM state enum, ID constant and error-code constants in shared package apb_pkg.
REQ-034 SHALL put the storage array and its write port in sub-module apb_regfile; FSM, decode and counter stay in apb_slave_regs.

Verification
REQ-035 SHALL cover: reset, then write 0x0000_0004 <- 32'hDEAD_BEEF with WAIT_CYCLES=2 -> pready high on cycle 3 after SETUP, pslverr=0; read back gives prdata=32'hDEAD_BEEF.
REQ-036 SHALL cover: read 0x0000_0000 -> prdata=32'hA5B0_0001; write 0x0 <- 32'h1234 -> pslverr=1, re-read still ID.
REQ-037 SHALL cover: read 0x0000_0102 (unaligned) and 0x0000_1000 (out of range) -> pslverr=1, prdata=0.
REQ-038 SHALL cover: back-to-back writes to 0x08 and 0x0C with no IDLE between -> both committed, two pready pulses each WAIT_CYCLES+1 cycles after their SETUP.
REQ-039 SHALL cover: psel dropped in mid-ACCESS of a write to 0x10, and separately hresetn pulsed mid-ACCESS -> register 0x10 unchanged (0), no pready, state IDLE.
REQ-040 SHALL cover: build without APB_SLAVE_WAIT_STATES_EN -> every pready asserted in the first ACCESS cycle.
